csr_unit: RTL and testbench

Control/status register unit inside Riscv151, in the execute stage, directly upstream of the top-level `csr` output port.
- Executes Zicsr instructions: csrrw, csrrs, csrrc and their immediate forms; the decoder muxes the immediate forms onto csr_wdata.
- Holds the tohost register (0x51E) that drives `csr`. The pass/fail result of every software test is reported through this register.
- Maintains 64-bit cycle and instret counters for software performance measurement.

---
 rtl/riscv151_csr_pkg.sv | 71 +++++++
 rtl/csr_counter64.sv | 47 ++++
 rtl/csr_unit.sv | 127 ++++++++++++
 tb/tb_csr_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv151_csr_pkg.sv
// Shared definitions for the Riscv151 CSR unit.
// Holds the supported CSR addresses, the csr_op encoding, the reset constants
// and a small address decoder. The decoder maps each address onto the
// physical register it touches and whether that alias is read-only.
`timescale 1ns/1ps
package riscv151_csr_pkg;

  // CSR address map
  localparam logic [11:0] CSR_TOHOST    = 12'h51E;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // Reset constants
  localparam logic [31:0] RESET_TOHOST_DEFAULT = 32'h0000_0000;
  localparam logic [63:0] COUNTER_RESET        = 64'd0;

  // csr_op encoding; 2'b00 is a no-op
  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_e;

  // Physical register selected by an address
  typedef enum logic [2:0] {
    SelNone,
    SelTohost,
    SelCycleLo,
    SelCycleHi,
    SelInstretLo,
    SelInstretHi
  } csr_sel_e;

  typedef struct packed {
    csr_sel_e sel;
    logic     ro;
  } csr_decode_t;

  // The user-mode counter aliases (0xCxx) are read-only views of the same
  // counters that the machine-mode aliases (0xBxx) can write.
  function automatic csr_decode_t csr_decode(input logic [11:0] addr,
                                             input logic [11:0] tohost_addr);
    csr_decode_t d;
    d.sel = SelNone;
    d.ro  = 1'b0;
    if (addr == tohost_addr) begin
      d.sel = SelTohost;
    end else begin
      case (addr)
        CSR_CYCLE:     begin d.sel = SelCycleLo;   d.ro = 1'b1; end
        CSR_CYCLEH:    begin d.sel = SelCycleHi;   d.ro = 1'b1; end
        CSR_INSTRET:   begin d.sel = SelInstretLo; d.ro = 1'b1; end
        CSR_INSTRETH:  begin d.sel = SelInstretHi; d.ro = 1'b1; end
        CSR_MCYCLE:    d.sel = SelCycleLo;
        CSR_MCYCLEH:   d.sel = SelCycleHi;
        CSR_MINSTRET:  d.sel = SelInstretLo;
        CSR_MINSTRETH: d.sel = SelInstretHi;
        default:       d.sel = SelNone;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit performance counter with 32-bit half write ports.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset (clears the count)
//   inc       - add one to the whole counter this cycle
//   wr_lo     - load wdata into bits [31:0]
//   wr_hi     - load wdata into bits [63:32]
//   wdata     - write data for either half
//   value     - current count
// A half write takes priority over the increment: the written half takes
// wdata and the other half holds, with no carry between them.
`timescale 1ns/1ps
module csr_counter64
  import riscv151_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo) begin
      cnt_d[31:0] = wdata;
    end else if (wr_hi) begin
      cnt_d[63:32] = wdata;
    end else if (inc) begin
      cnt_d = cnt_q + 64'd1;  // wraps naturally at 2^64
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= COUNTER_RESET;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Control/status register unit for the Riscv151 execute stage.
// Executes csrrw/csrrs/csrrc (immediate forms arrive already muxed onto
// csr_wdata), holds the tohost register and the cycle/instret counters.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   csr_en       - a CSR instruction is in execute this cycle
//   csr_op       - 01 RW, 10 RS, 11 RC, 00 no-op
//   csr_addr     - CSR address
//   csr_wdata    - rs1 value or zero-extended uimm
//   src_is_zero  - rs1 index / uimm is zero (suppresses RS/RC writes)
//   stall        - blocks writes and the instret increment
//   instr_retire - an instruction retires this cycle
//   csr_rdata    - old CSR value (combinational), zero when idle/illegal
//   illegal      - unsupported address or write to a read-only CSR
//   tohost       - registered tohost value
//   tohost_wr    - one-cycle pulse after each committed tohost write
`timescale 1ns/1ps
module csr_unit
  import riscv151_csr_pkg::*;
#(
  parameter logic [31:0] RESET_TOHOST = RESET_TOHOST_DEFAULT,
  parameter logic [11:0] TOHOST_ADDR  = CSR_TOHOST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        src_is_zero,
  input  logic        stall,
  input  logic        instr_retire,
  output logic [31:0] csr_rdata,
  output logic        illegal,
  output logic [31:0] tohost,
  output logic        tohost_wr
);

  csr_decode_t dec;
  csr_op_e     op;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        writes;
  logic        illegal_c;
  logic        wr_req;
  logic [63:0] cycle_val;
  logic [63:0] instret_val;
  logic [31:0] tohost_q;
  logic        tohost_wr_q;

  assign dec = csr_decode(csr_addr, TOHOST_ADDR);
  assign op  = csr_op_e'(csr_op);

  // Current value of the addressed register
  always_comb begin
    old_val = '0;
    case (dec.sel)
      SelTohost:    old_val = tohost_q;
      SelCycleLo:   old_val = cycle_val[31:0];
      SelCycleHi:   old_val = cycle_val[63:32];
      SelInstretLo: old_val = instret_val[31:0];
      SelInstretHi: old_val = instret_val[63:32];
      default:      old_val = '0;
    endcase
  end

  // RW always writes; RS/RC only write with a non-zero source. This is what
  // makes csrrs rd, cycle, x0 a legal read of a read-only counter.
  assign writes = (op == CSR_RW) || ((op != CSR_NOP) && !src_is_zero);

  assign illegal_c = csr_en && (op != CSR_NOP) &&
                     ((dec.sel == SelNone) || (dec.ro && writes));

  assign illegal   = illegal_c;
  assign csr_rdata = (csr_en && !illegal_c) ? old_val : '0;

  always_comb begin
    new_val = csr_wdata;
    unique case (op)
      CSR_RW:  new_val = csr_wdata;
      CSR_RS:  new_val = old_val | csr_wdata;
      CSR_RC:  new_val = old_val & ~csr_wdata;
      CSR_NOP: new_val = csr_wdata;
    endcase
  end

  // A stalled instruction is re-presented, so committing only when stall is
  // low gives exactly one commit per instruction.
  assign wr_req = csr_en && !stall && !illegal_c && (op != CSR_NOP) && writes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tohost_q    <= RESET_TOHOST;
      tohost_wr_q <= 1'b0;
    end else begin
      tohost_wr_q <= wr_req && (dec.sel == SelTohost);
      if (wr_req && (dec.sel == SelTohost)) begin
        tohost_q <= new_val;
      end
    end
  end

  assign tohost    = tohost_q;
  assign tohost_wr = tohost_wr_q;

  // cycle counts every cycle out of reset, stalled or not
  csr_counter64 u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr_req && (dec.sel == SelCycleLo)),
    .wr_hi (wr_req && (dec.sel == SelCycleHi)),
    .wdata (new_val),
    .value (cycle_val)
  );

  csr_counter64 u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retire && !stall),
    .wr_lo (wr_req && (dec.sel == SelInstretLo)),
    .wr_hi (wr_req && (dec.sel == SelInstretHi)),
    .wdata (new_val),
    .value (instret_val)
  );

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios plus randomized CSR
// traffic, checked against an arithmetic reference model of the registers.
`timescale 1ns/1ps
module tb_csr_unit;

  logic        clk;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        src_is_zero;
  logic        stall;
  logic        instr_retire;
  logic [31:0] csr_rdata;
  logic        illegal;
  logic [31:0] tohost;
  logic        tohost_wr;

  csr_unit dut (
    .clk          (clk),
    .rst          (rst),
    .csr_en       (csr_en),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .src_is_zero  (src_is_zero),
    .stall        (stall),
    .instr_retire (instr_retire),
    .csr_rdata    (csr_rdata),
    .illegal      (illegal),
    .tohost       (tohost),
    .tohost_wr    (tohost_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  longint unsigned m_cycle;
  longint unsigned m_instret;
  logic [31:0]     m_tohost;
  bit              m_tohost_wr;

  function automatic bit m_known(input logic [11:0] a);
    case (a)
      12'h51E, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return (a == 12'hC00) || (a == 12'hC80) || (a == 12'hC02) || (a == 12'hC82);
  endfunction

  function automatic logic [31:0] m_value(input logic [11:0] a);
    case (a)
      12'h51E:          return m_tohost;
      12'hC00, 12'hB00: return m_cycle[31:0];
      12'hC80, 12'hB80: return m_cycle[63:32];
      12'hC02, 12'hB02: return m_instret[31:0];
      12'hC82, 12'hB82: return m_instret[63:32];
      default:          return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_cycle     = 0;
    m_instret   = 0;
    m_tohost    = 32'h0;
    m_tohost_wr = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model
  // across the edge, check registered outputs. Called at posedge+1.
  task automatic step(input bit en, input logic [1:0] op, input logic [11:0] addr,
                      input logic [31:0] wd, input bit sz, input bit st, input bit ret,
                      output logic [31:0] seen);
    bit              wr, ill, commit;
    logic [31:0]     old, nv, nt;
    longint unsigned nc, ni;
    csr_en = en; csr_op = op; csr_addr = addr; csr_wdata = wd;
    src_is_zero = sz; stall = st; instr_retire = ret;
    #1;
    wr  = (op == 2'b01) || (op != 2'b00 && !sz);
    ill = en && (op != 2'b00) && (!m_known(addr) || (m_ro(addr) && wr));
    old = (en && !ill) ? m_value(addr) : 32'h0;
    check_eq("illegal", illegal, ill);
    check_eq("rdata", csr_rdata, old);
    seen = csr_rdata;
    commit = en && !st && !ill && (op != 2'b00) && wr;
    nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
    nc = m_cycle + 1;
    ni = m_instret + ((ret && !st) ? 1 : 0);
    nt = m_tohost;
    if (commit) begin
      case (addr)
        12'h51E: nt = nv;
        12'hB00: nc = {m_cycle[63:32], nv};
        12'hB80: nc = {nv, m_cycle[31:0]};
        12'hB02: ni = {m_instret[63:32], nv};
        12'hB82: ni = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    m_cycle     = nc;
    m_instret   = ni;
    m_tohost    = nt;
    m_tohost_wr = commit && (addr == 12'h51E);
    check_eq("tohost", tohost, m_tohost);
    check_eq("tohost_wr", tohost_wr, m_tohost_wr);
  endtask

  task automatic idle(input int n);
    logic [31:0] s;
    for (int i = 0; i < n; i++) step(0, 2'b00, 12'h000, 32'h0, 0, 0, 0, s);
  endtask

  logic [11:0] addr_pool [12] = '{12'h51E, 12'h51E, 12'h51E, 12'hC00, 12'hC80, 12'hC02,
                                  12'hC82, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h300};

  initial begin
    logic [31:0] s;
    logic [31:0] wd;
    bit          sz;
    rst = 1'b0;
    csr_en = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    src_is_zero = 0; stall = 0; instr_retire = 0;
    m_reset();
    #2;
    check_eq("rst_tohost", tohost, 32'h0);
    check_eq("rst_tohost_wr", tohost_wr, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Cycle counter reads 100 after 100 edges out of reset
    idle(100);
    step(1, 2'b10, 12'hC00, 32'h0, 1, 0, 0, s);
    check_eq("cycle_100", s, 32'd100);

    // csrrw tohost, then set/clear
    step(1, 2'b01, 12'h51E, 32'h1, 0, 0, 1, s);
    check_eq("rw_old", s, 32'h0);
    check_eq("rw_tohost", tohost, 32'h1);
    idle(1);
    step(1, 2'b10, 12'h51E, 32'h6, 0, 0, 1, s);
    check_eq("rs_tohost", tohost, 32'h7);
    step(1, 2'b11, 12'h51E, 32'h3, 0, 0, 1, s);
    check_eq("rc_tohost", tohost, 32'h4);
    step(1, 2'b10, 12'h51E, 32'h0, 1, 0, 1, s);
    check_eq("rs_zero_rdata", s, 32'h4);

    // Stall hold, then release commits exactly once
    for (int i = 0; i < 5; i++) step(1, 2'b01, 12'h51E, 32'hDEAD, 0, 1, 1, s);
    step(1, 2'b01, 12'h51E, 32'hDEAD, 0, 0, 1, s);
    check_eq("stall_release", tohost, 32'hDEAD);
    idle(1);
    step(1, 2'b10, 12'hC02, 32'h0, 1, 0, 0, s);

    // Counter wrap through the machine-mode aliases
    step(1, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0, 0, s);
    step(1, 2'b01, 12'hB80, 32'hFFFF_FFFF, 0, 0, 0, s);
    idle(1);
    step(1, 2'b10, 12'hC00, 32'h0, 1, 0, 0, s);
    check_eq("wrap_lo", s, 32'h1 - 32'h1);
    step(1, 2'b10, 12'hC80, 32'h0, 1, 0, 0, s);
    check_eq("wrap_hi", s, 32'h0);

    // Illegal accesses
    step(1, 2'b01, 12'hC00, 32'h1234, 0, 0, 0, s);
    check_eq("ill_ro_flag", illegal, 1'b1);
    step(1, 2'b01, 12'h300, 32'h1234, 0, 0, 0, s);
    step(1, 2'b11, 12'hC82, 32'h1, 0, 0, 0, s);
    step(1, 2'b10, 12'hC00, 32'h0, 1, 0, 0, s);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      sz = ($urandom_range(0, 3) == 0);
      wd = sz ? 32'h0 : (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom);
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           addr_pool[$urandom_range(0, 11)], wd, sz,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, s);
    end

    // Async reset between edges with non-zero state
    step(1, 2'b01, 12'h51E, 32'h7, 0, 0, 0, s);
    step(1, 2'b01, 12'hB80, 32'h0, 0, 0, 0, s);
    step(1, 2'b01, 12'hB00, 32'd499, 0, 0, 0, s);
    step(1, 2'b01, 12'hB02, 32'd42, 0, 0, 0, s);
    rst = 1'b0;
    m_reset();
    #1;
    check_eq("arst_tohost", tohost, 32'h0);
    check_eq("arst_tohost_wr", tohost_wr, 1'b0);
    csr_en = 1; csr_op = 2'b10; src_is_zero = 1; csr_wdata = 0; csr_addr = 12'hC00;
    #1;
    check_eq("arst_cycle", csr_rdata, 32'h0);
    csr_addr = 12'hC02;
    #1;
    check_eq("arst_instret", csr_rdata, 32'h0);
    rst = 1'b1;
    idle(3);
    step(1, 2'b10, 12'hC00, 32'h0, 1, 0, 0, s);
    check_eq("post_arst_cycle", s, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
